// File: rtl/orc_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : orc_mem_arb_pkg
//  Description : Shared types and constants for the ORC_R32I memory arbiter:
//                FSM state encoding, requester ids and timeout read data.
//  Revision    : 1.0 - initial release
// ============================================================================
package orc_mem_arb_pkg;

    // Arbiter FSM states; CONSOLE is only reachable with MEM_ARB_CONSOLE_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        CONSOLE = 2'd2
    } arb_state_t;

    // Requester ids, also used as bit positions of the one-hot grant vector
    typedef enum logic [1:0] {
        REQ_W = 2'd0,
        REQ_R = 2'd1,
        REQ_I = 2'd2
    } req_id_t;

    localparam int          REQ_NUM      = 3;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage : orc_mem_arb_pkg
`default_nettype wire

// File: rtl/orc_arb_prio.sv
`default_nettype none
// ============================================================================
//  Module      : orc_arb_prio
//  Description : Combinational fixed-priority winner select for the memory
//                arbiter. Order is write > data read > inst, except that a
//                waiting inst request wins outright once the stall counter
//                has saturated. Inputs are already masked by the caller.
//  Revision    : 1.0 - initial release
// ============================================================================
module orc_arb_prio
    import orc_mem_arb_pkg::*;
(
    input  logic               i_req_w,
    input  logic               i_req_r,
    input  logic               i_req_i,
    input  logic               i_stall_sat,
    output logic [REQ_NUM-1:0] o_grant
);

    // One-hot grant: starvation guard first, then fixed order
    always_comb begin
        o_grant = '0;
        if (i_req_i && i_stall_sat) begin
            o_grant[REQ_I] = 1'b1;
        end else if (i_req_w) begin
            o_grant[REQ_W] = 1'b1;
        end else if (i_req_r) begin
            o_grant[REQ_R] = 1'b1;
        end else if (i_req_i) begin
            o_grant[REQ_I] = 1'b1;
        end
    end

endmodule : orc_arb_prio
`default_nettype wire

// File: rtl/orc_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : orc_mem_arbiter
//  Description : Shares one single-port memory backend between the core's
//                inst read, data read and data write masters. Fixed priority
//                with an inst starvation guard, one-cycle completion acks and
//                a backend timeout that completes with TIMEOUT_DATA.
//                Optional feature macro: MEM_ARB_CONSOLE_EN (console byte
//                port at CONSOLE_ADDR, bypassing the backend).
//  Revision    : 1.0 - initial release
// ============================================================================
module orc_mem_arbiter
    import orc_mem_arb_pkg::*;
#(
    parameter int          MAX_STALL      = 4,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] CONSOLE_ADDR   = 32'h1000_0000
)(
    input  logic        i_clk,
    input  logic        i_reset_sync,
    input  logic        i_inst_read,
    output logic        o_inst_read_ack,
    input  logic [31:0] i_inst_read_addr,
    output logic [31:0] o_inst_read_data,
    input  logic        i_master_read,
    output logic        o_master_read_ack,
    input  logic [31:0] i_master_read_addr,
    output logic [31:0] o_master_read_data,
    input  logic        i_master_write,
    output logic        o_master_write_ack,
    input  logic [31:0] i_master_write_addr,
    input  logic [31:0] i_master_write_data,
    input  logic [3:0]  i_master_write_byte_enable,
    output logic        o_mem_en,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_err
`ifdef MEM_ARB_CONSOLE_EN
    ,
    output logic        o_console_valid,
    output logic [7:0]  o_console_data
`endif
);

    localparam int                   c_stall_w    = $clog2(MAX_STALL + 1);
    localparam int                   c_timer_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_stall_w-1:0] c_stall_max  = c_stall_w'(MAX_STALL);
    localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(TIMEOUT_CYCLES - 1);

    arb_state_t           r_state;
    arb_state_t           w_next_state;
    logic [c_stall_w-1:0] r_stall;
    logic [c_timer_w-1:0] r_timer;
    logic [REQ_NUM-1:0]   r_winner;
    logic [REQ_NUM-1:0]   w_grant;
    logic                 w_idle;
    logic                 w_busy;
    logic                 w_req_w;
    logic                 w_req_r;
    logic                 w_req_i;
    logic                 w_any_grant;
    logic                 w_data_grant;
    logic                 w_console_hit;
    logic                 w_timeout;
    logic                 w_done;
    logic                 w_issue;
    logic                 w_console_start;
    logic                 w_console_end;
    logic [31:0]          w_rdata;

    assign w_idle = (r_state == IDLE);
    assign w_busy = (r_state == BUSY);

    // A requester being acked this cycle sits out, so a held request is not re-issued
    assign w_req_w = w_idle & i_master_write & ~o_master_write_ack;
    assign w_req_r = w_idle & i_master_read  & ~o_master_read_ack;
    assign w_req_i = w_idle & i_inst_read    & ~o_inst_read_ack;

    orc_arb_prio u_prio (
        .i_req_w     (w_req_w),
        .i_req_r     (w_req_r),
        .i_req_i     (w_req_i),
        .i_stall_sat (r_stall == c_stall_max),
        .o_grant     (w_grant)
    );

    assign w_any_grant  = |w_grant;
    assign w_data_grant = w_grant[REQ_W] | w_grant[REQ_R];

`ifdef MEM_ARB_CONSOLE_EN
    assign w_console_hit = w_grant[REQ_W] && (i_master_write_addr == CONSOLE_ADDR);
`else
    assign w_console_hit = 1'b0;
`endif

    // Timer reaches its last value on the TIMEOUT_CYCLES-th BUSY cycle
    assign w_timeout = w_busy && !i_mem_ack && (r_timer == c_timer_last);
    assign w_done    = w_busy && (i_mem_ack || w_timeout);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset_sync) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any_grant) w_next_state = w_console_hit ? CONSOLE : BUSY;
            BUSY:    if (w_done)      w_next_state = IDLE;
            CONSOLE: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output control decode
    always_comb begin
        w_issue         = 1'b0;
        w_console_start = 1'b0;
        w_console_end   = 1'b0;
        w_rdata         = TIMEOUT_DATA;
        case (r_state)
            IDLE: begin
                w_issue         = w_any_grant && !w_console_hit;
                w_console_start = w_any_grant &&  w_console_hit;
            end
            BUSY:    w_rdata       = i_mem_ack ? i_mem_rdata : TIMEOUT_DATA;
            CONSOLE: w_console_end = 1'b1;
            default: ;
        endcase
    end

    // Starvation guard: count data grants made while inst is waiting
    always_ff @(posedge i_clk) begin
        if (i_reset_sync || !i_inst_read || w_grant[REQ_I]) begin
            r_stall <= '0;
        end else if (w_data_grant && (r_stall != c_stall_max)) begin
            r_stall <= r_stall + c_stall_w'(1);
        end
    end

    // BUSY cycle counter, restarted on every backend issue
    always_ff @(posedge i_clk) begin
        if (i_reset_sync || w_issue) begin
            r_timer <= '0;
        end else if (w_busy) begin
            r_timer <= r_timer + c_timer_w'(1);
        end
    end

    // Registered backend request, completion acks and read data
    always_ff @(posedge i_clk) begin
        if (i_reset_sync) begin
            o_mem_en           <= 1'b0;
            o_mem_we           <= 1'b0;
            o_mem_addr         <= '0;
            o_mem_wdata        <= '0;
            o_mem_be           <= '0;
            o_inst_read_ack    <= 1'b0;
            o_master_read_ack  <= 1'b0;
            o_master_write_ack <= 1'b0;
            o_inst_read_data   <= '0;
            o_master_read_data <= '0;
            o_err              <= 1'b0;
            r_winner           <= '0;
        end else begin
            o_mem_en           <= w_issue;
            o_err              <= w_timeout;
            o_inst_read_ack    <= w_done && r_winner[REQ_I];
            o_master_read_ack  <= w_done && r_winner[REQ_R];
            o_master_write_ack <= (w_done && r_winner[REQ_W]) || w_console_end;
            if (w_any_grant) begin
                r_winner <= w_grant;
            end
            if (w_issue) begin
                o_mem_we <= w_grant[REQ_W];
                if (w_grant[REQ_W]) begin
                    o_mem_addr  <= i_master_write_addr;
                    o_mem_wdata <= i_master_write_data;
                    o_mem_be    <= i_master_write_byte_enable;
                end else begin
                    o_mem_addr  <= w_grant[REQ_R] ? i_master_read_addr : i_inst_read_addr;
                    o_mem_be    <= 4'hF;
                end
            end
            if (w_done && r_winner[REQ_I]) begin
                o_inst_read_data <= w_rdata;
            end
            if (w_done && r_winner[REQ_R]) begin
                o_master_read_data <= w_rdata;
            end
        end
    end

`ifdef MEM_ARB_CONSOLE_EN
    // Console byte strobe; the write ack follows in the CONSOLE cycle's successor
    always_ff @(posedge i_clk) begin
        if (i_reset_sync) begin
            o_console_valid <= 1'b0;
            o_console_data  <= '0;
        end else begin
            o_console_valid <= w_console_start;
            if (w_console_start) begin
                o_console_data <= i_master_write_data[7:0];
            end
        end
    end
`endif

endmodule : orc_mem_arbiter
`default_nettype wire

// File: tb/tb_orc_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_orc_mem_arbiter
//  Description : Self-checking bench for orc_mem_arbiter: cycle vector table
//                for single accesses and write/read ordering, plus hand
//                sequences for starvation guard, timeout, reset in BUSY and
//                (with MEM_ARB_CONSOLE_EN) the console path.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_orc_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_read = 1'b0;
    logic        inst_ack;
    logic [31:0] inst_addr = 32'h0000_0100;
    logic [31:0] inst_data;
    logic        mread = 1'b0;
    logic        mread_ack;
    logic [31:0] mread_addr = 32'h0000_0300;
    logic [31:0] mread_data;
    logic        mwrite = 1'b0;
    logic        mwrite_ack;
    logic [31:0] mwrite_addr = 32'h0000_0200;
    logic [31:0] mwrite_data = 32'hA5A5_A5A5;
    logic [3:0]  mwrite_be = 4'b0011;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        err;
`ifdef MEM_ARB_CONSOLE_EN
    logic        con_valid;
    logic [7:0]  con_data;
`endif

    orc_mem_arbiter #(
        .MAX_STALL      (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_clk                      (clk),
        .i_reset_sync               (rst),
        .i_inst_read                (inst_read),
        .o_inst_read_ack            (inst_ack),
        .i_inst_read_addr           (inst_addr),
        .o_inst_read_data           (inst_data),
        .i_master_read              (mread),
        .o_master_read_ack          (mread_ack),
        .i_master_read_addr         (mread_addr),
        .o_master_read_data         (mread_data),
        .i_master_write             (mwrite),
        .o_master_write_ack         (mwrite_ack),
        .i_master_write_addr        (mwrite_addr),
        .i_master_write_data        (mwrite_data),
        .i_master_write_byte_enable (mwrite_be),
        .o_mem_en                   (mem_en),
        .o_mem_we                   (mem_we),
        .o_mem_addr                 (mem_addr),
        .o_mem_wdata                (mem_wdata),
        .o_mem_be                   (mem_be),
        .i_mem_ack                  (mem_ack),
        .i_mem_rdata                (mem_rdata),
        .o_err                      (err)
`ifdef MEM_ARB_CONSOLE_EN
        ,
        .o_console_valid            (con_valid),
        .o_console_data             (con_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        inst, rd, wr, ack;
        logic [31:0] rdata;
        logic [5:0]  ctrl;   // {en, we, inst_ack, read_ack, write_ack, err}
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] idata;
        logic [31:0] ddata;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic i, input logic r, input logic w, input logic a,
                                input logic [31:0] rd, input logic [5:0] c, input logic [31:0] ad,
                                input logic [3:0] b, input logic [31:0] id, input logic [31:0] dd);
        vec_t v;
        v.inst = i; v.rd = r; v.wr = w; v.ack = a; v.rdata = rd;
        v.ctrl = c; v.addr = ad; v.be = b; v.idata = id; v.ddata = dd;
        return v;
    endfunction

    function automatic logic [5:0] ctrl_now();
        return {mem_en, mem_we, inst_ack, mread_ack, mwrite_ack, err};
    endfunction

    initial begin
        vec_t        vecs[10];
        logic [31:0] got[10];
        logic [31:0] exp_order[10];
        int          ng;
        int          bad;
        logic        pend;

        // inst read, then write+read collision (write wins), read after write ack
        vecs[0] = mk(1,0,0,0, 32'h0,         6'b100000, 32'h100, 4'hF, 32'h0,  32'h0);
        vecs[1] = mk(1,0,0,0, 32'h0,         6'b000000, 32'h100, 4'hF, 32'h0,  32'h0);
        vecs[2] = mk(1,0,0,1, 32'h13,        6'b001000, 32'h100, 4'hF, 32'h13, 32'h0);
        vecs[3] = mk(0,0,0,0, 32'h0,         6'b000000, 32'h100, 4'hF, 32'h13, 32'h0);
        vecs[4] = mk(0,1,1,0, 32'h0,         6'b110000, 32'h200, 4'h3, 32'h13, 32'h0);
        vecs[5] = mk(0,1,1,0, 32'h0,         6'b010000, 32'h200, 4'h3, 32'h13, 32'h0);
        vecs[6] = mk(0,1,1,1, 32'h5555,      6'b010010, 32'h200, 4'h3, 32'h13, 32'h0);
        vecs[7] = mk(0,1,0,0, 32'h0,         6'b100000, 32'h300, 4'hF, 32'h13, 32'h0);
        vecs[8] = mk(0,1,0,1, 32'hCAFE_0001, 6'b000100, 32'h300, 4'hF, 32'h13, 32'hCAFE_0001);
        vecs[9] = mk(0,0,0,0, 32'h0,         6'b000000, 32'h300, 4'hF, 32'h13, 32'hCAFE_0001);

        exp_order = '{32'h200, 32'h300, 32'h200, 32'h300, 32'h100,
                      32'h200, 32'h300, 32'h200, 32'h300, 32'h100};

        // Reset state
        repeat (3) tick();
        check("reset ctrl",  ctrl_now(), 6'b0);
        check("reset addr",  mem_addr,   32'h0);
        check("reset wdata", mem_wdata,  32'h0);
        check("reset be",    mem_be,     4'h0);
        check("reset idata", inst_data,  32'h0);
        check("reset ddata", mread_data, 32'h0);
        rst = 1'b0;
        tick();

        // Vector table
        for (int i = 0; i < 10; i++) begin
            inst_read = vecs[i].inst;
            mread     = vecs[i].rd;
            mwrite    = vecs[i].wr;
            mem_ack   = vecs[i].ack;
            mem_rdata = vecs[i].rdata;
            tick();
            check($sformatf("vec%0d ctrl",  i), ctrl_now(),  vecs[i].ctrl);
            check($sformatf("vec%0d addr",  i), mem_addr,    vecs[i].addr);
            check($sformatf("vec%0d be",    i), mem_be,      vecs[i].be);
            check($sformatf("vec%0d idata", i), inst_data,   vecs[i].idata);
            check($sformatf("vec%0d ddata", i), mread_data,  vecs[i].ddata);
        end
        check("wdata held after read", mem_wdata, 32'hA5A5_A5A5);

        // Starvation guard: write and read alternate while inst waits
        inst_read = 1'b1; mread = 1'b1; mwrite = 1'b1;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        ng = 0; pend = 1'b0;
        for (int cyc = 0; cyc < 200 && ng < 10; cyc++) begin
            tick();
            mem_ack = 1'b0;
            if (pend) begin
                mem_ack = 1'b1;
                pend    = 1'b0;
            end
            if (mem_en) begin
                got[ng] = mem_addr;
                ng++;
                pend = 1'b1;
            end
        end
        check("stall grant count", 64'(ng), 64'd10);
        for (int g = 0; g < 10; g++) begin
            check($sformatf("stall grant%0d addr", g), got[g], exp_order[g]);
        end
        tick();
        mem_ack = 1'b1;
        tick();
        check("stall final inst ack", 64'(inst_ack), 64'd1);
        inst_read = 1'b0; mread = 1'b0; mwrite = 1'b0; mem_ack = 1'b0;
        tick();
        tick();

        // Timeout: backend never acks a data read
        mread = 1'b1;
        tick();
        check("timeout issue en", 64'(mem_en), 64'd1);
        bad = 0;
        for (int k = 1; k < 16; k++) begin
            tick();
            if (mread_ack || err) bad++;
        end
        check("timeout early ack/err", 64'(bad), 64'd0);
        tick();
        check("timeout ctrl", ctrl_now(), 6'b000101);
        check("timeout data", mread_data, 32'hDEAD_BEEF);
        mread = 1'b0;
        mem_ack = 1'b1;   // late ack in IDLE must be ignored
        tick();
        check("post timeout ctrl", ctrl_now(), 6'b0);
        mem_ack = 1'b0;
        tick();

        // Reset two cycles into BUSY
        inst_read = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rst busy ctrl",  ctrl_now(), 6'b0);
        check("rst busy addr",  mem_addr,   32'h0);
        check("rst busy idata", inst_data,  32'h0);
        rst = 1'b0; inst_read = 1'b0; mem_ack = 1'b1;
        tick();
        check("rst stale ack ignored", ctrl_now(), 6'b0);
        mem_ack = 1'b0;
        mread = 1'b1;
        tick();
        check("rst new issue ctrl", ctrl_now(), 6'b100000);
        check("rst new issue addr", mem_addr,   32'h300);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0000_0077;
        tick();
        check("rst new ack ctrl", ctrl_now(), 6'b000100);
        check("rst new data",     mread_data, 32'h0000_0077);
        mread = 1'b0; mem_ack = 1'b0;
        tick();

`ifdef MEM_ARB_CONSOLE_EN
        // Console write bypasses the backend
        mwrite_addr = 32'h1000_0000; mwrite_data = 32'h0000_0041;
        mwrite = 1'b1;
        tick();
        check("console valid", 64'(con_valid), 64'd1);
        check("console data",  con_data,       8'h41);
        check("console ctrl",  ctrl_now(),     6'b0);
        tick();
        check("console ack ctrl", ctrl_now(),     6'b000010);
        check("console valid low", 64'(con_valid), 64'd0);
        mwrite = 1'b0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_orc_mem_arbiter
`default_nettype wire
